alu_issue_wb: RTL and testbench
===============================

Name: alu_issue_wb

Overview:
- Sequencing and storage stage around the existing 4-bit `alu` block.
- Accepts one instruction at a time through a valid/ready handshake.
- Reads two operands from a 4-entry, 4-bit register file and drives the `alu` inputs (A, B, c_in, ALUOP, l).
- Captures R/zero/c_out/sign and writes the result back to the register file and a flags register.
- The `alu` itself stays purely combinational; this block owns all state.

Parameters:
- W, 4: data width; fixed to the `alu` width, no other value supported.
- NREG, 4: register count; address width is 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept an instruction
- in_l  in  1  logic(1)/arith(0) select, forwarded to alu l
- in_aluop  in  2  forwarded to alu ALUOP
- in_rd  in  2  destination register
- in_rs1  in  2  source for alu A
- in_rs2  in  2  source for alu B
- in_usec  in  1  1: alu c_in = flag_c; 0: c_in = 0
- in_wen  in  1  1: write rd; 0: update flags only
- ld_en  in  1  direct register load
- ld_addr  in  2  load address
- ld_data  in  4  load data
- alu_a  out  4  to alu A
- alu_b  out  4  to alu B
- alu_cin  out  1  to alu c_in
- alu_aluop  out  2  to alu ALUOP
- alu_l  out  1  to alu l
- alu_r  in  4  from alu R
- alu_zero  in  1  from alu zero
- alu_cout  in  1  from alu c_out
- alu_sign  in  1  from alu sign
- flag_z  out  1  zero flag
- flag_c  out  1  carry flag
- flag_s  out  1  sign flag
- done  out  1  one-cycle pulse in the writeback cycle
- dbg_addr  in  2  debug read address
- dbg_data  out  4  combinational value of regs[dbg_addr]

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all regs=0; flags=0; IR=0; result latch=0; done=0.
  - in_ready=1 once reset is released.
- FSM states: IDLE -> EXEC -> WB -> IDLE. One instruction per 3 cycles; no pipelining.
- IDLE:
  - in_ready=1.
  - If in_valid, latch in_l, in_aluop, in_rd, in_rs1, in_rs2, in_usec, in_wen into IR and go to EXEC. Otherwise stay in IDLE.
  - If ld_en, write regs[ld_addr]=ld_data at the clock edge.
- EXEC:
  - in_ready=0.
  - alu_a=regs[IR.rs1], alu_b=regs[IR.rs2], alu_cin=IR.usec & flag_c, alu_aluop=IR.aluop, alu_l=IR.l.
  - At the end of EXEC, register alu_r, alu_zero, alu_cout and alu_sign into the result latch; go to WB.
- WB:
  - in_ready=0; done=1.
  - At the end of WB: if IR.wen, regs[IR.rd]=result.
  - flag_z and flag_s are always updated.
  - flag_c is updated only if IR.l==0; when IR.l==1 it holds its value.
  - Go to IDLE.
- ALU-side outputs are driven from IR and the register file in every state; they are don't-care outside EXEC but must be stable (no X after reset).
- Load / instruction interactions:
  - ld_en is ignored in EXEC and WB.
  - If ld_en and an accepted instruction occur in the same IDLE cycle, the load commits first, so EXEC reads the loaded value.
- in_valid while in_ready=0: the instruction is not accepted; the source must hold it until IDLE.
- Same register as source and destination (rs1==rs2==rd) is legal; reads occur in EXEC, before the WB write.
- Reset mid-operation (EXEC or WB): abort, return to IDLE, no write, done=0.
- All arithmetic wraps at 4 bits inside the `alu`; this block does no width extension.

Decomposition:
- Shared package `alu_pkg`:
  - state encoding (IDLE=2'b00, EXEC=2'b01, WB=2'b10);
  - ALUOP/l constants (for example OP_ADD = l=0, ALUOP=2'b10);
  - instruction-register field layout.
- One sub-module is natural: `regfile4x4`, with 2 combinational read ports, 1 debug read port and 1 write port. The load/writeback write select lives in the parent.

Test Plan:
- Reset then idle: dbg_data=0 for all addresses; flags=000; in_ready=1; done=0.
- Basic ADD: load r1=5, r2=3; issue ADD rd=3, rs1=1, rs2=2, usec=0 -> alu_a=5, alu_b=3 in EXEC; done 2 cycles after accept; r3=8, Z=0, C=0, S=1.
- Carry chain:
  - r1=F, r2=1; ADD rd=0 -> r0=0, Z=1, C=1, S=0.
  - Then r1=2, r2=2; ADD with usec=1 -> alu_cin=1, r3=5, C=0.
- Logic op and flags-only write:
  - Set C=1, then issue l=1, wen=0, rd=1 -> r1 unchanged, C stays 1, Z and S follow alu_r.
- Backpressure and load collision:
  - Hold in_valid through EXEC/WB -> in_ready=0, exactly one instruction accepted per 3 cycles.
  - ld_en in EXEC -> ignored.
  - ld_en together with accept in IDLE -> EXEC sees the loaded value.
- Reset mid-operation: rst_n low during EXEC of a write to r2=7 -> r2=0, flags=0, state IDLE, no done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue/writeback stage.
//   - data width / register count / address width
//   - FSM state encoding (IDLE, EXEC, WB)
//   - ALUOP and l constants understood by the external alu block
//   - instruction-register field layout
package alu_pkg;

    localparam int W    = 4;
    localparam int NREG = 4;
    localparam int AW   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_t;

    // l selects the alu operation class; ALUOP selects within the class.
    localparam logic       L_ARITH = 1'b0;
    localparam logic       L_LOGIC = 1'b1;
    localparam logic [1:0] OP_PASS = 2'b00;  // l=0: A + c_in
    localparam logic [1:0] OP_SUB  = 2'b01;  // l=0: A - B
    localparam logic [1:0] OP_ADD  = 2'b10;  // l=0: A + B + c_in
    localparam logic [1:0] OP_DEC  = 2'b11;  // l=0: A - 1
    localparam logic [1:0] OP_AND  = 2'b00;  // l=1
    localparam logic [1:0] OP_OR   = 2'b01;  // l=1
    localparam logic [1:0] OP_XOR  = 2'b10;  // l=1
    localparam logic [1:0] OP_NOT  = 2'b11;  // l=1

    typedef struct packed {
        logic          l;
        logic [1:0]    aluop;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          usec;
        logic          wen;
    } ir_t;

endpackage

// File: rtl/regfile4x4.sv
// regfile4x4: 4-entry x 4-bit register file.
//   clk, rst_n          clock / asynchronous active-low clear of all entries
//   i_we/i_waddr/i_wdata  single synchronous write port
//   i_ra1 -> o_rd1        combinational read port 1
//   i_ra2 -> o_rd2        combinational read port 2
//   i_dbg_addr -> o_dbg_data  combinational debug read port
module regfile4x4
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_ra1,
    output logic [W-1:0]  o_rd1,
    input  logic [AW-1:0] i_ra2,
    output logic [W-1:0]  o_rd2,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [W-1:0]  o_dbg_data
);

    logic [W-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rd1      = r_mem[i_ra1];
    assign o_rd2      = r_mem[i_ra2];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: sequencing/storage stage wrapped around the combinational alu.
//   Instruction in : in_valid/in_ready handshake, in_l, in_aluop, in_rd,
//                    in_rs1, in_rs2, in_usec, in_wen
//   Direct load    : ld_en, ld_addr, ld_data (honoured only in IDLE)
//   To alu         : alu_a, alu_b, alu_cin, alu_aluop, alu_l
//   From alu       : alu_r, alu_zero, alu_cout, alu_sign
//   Status         : flag_z, flag_c, flag_s, done (one-cycle pulse in WB)
//   Debug          : dbg_addr -> dbg_data (register file read), dbg_state (FSM)
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is 1 only in IDLE; a source seeing in_ready=0
// keeps in_valid and the instruction fields stable until the transfer edge.
//
// Sequence per instruction: IDLE (accept) -> EXEC (alu result latched)
// -> WB (register/flags written) -> IDLE.
module alu_issue_wb
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_l,
    input  logic [1:0] in_aluop,
    input  logic [1:0] in_rd,
    input  logic [1:0] in_rs1,
    input  logic [1:0] in_rs2,
    input  logic       in_usec,
    input  logic       in_wen,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [1:0] alu_aluop,
    output logic       alu_l,
    input  logic [3:0] alu_r,
    input  logic       alu_zero,
    input  logic       alu_cout,
    input  logic       alu_sign,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_s,
    output logic       done,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data,
    output logic [1:0] dbg_state
);

    state_t       r_state;
    ir_t          r_ir;
    logic [W-1:0] r_res;
    logic         r_res_z;
    logic         r_res_c;
    logic         r_res_s;
    logic         r_flag_z;
    logic         r_flag_c;
    logic         r_flag_s;
    logic         r_in_ready;
    logic         r_done;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [W-1:0]  w_wdata;

    // Write-port select: direct loads own the port in IDLE, writeback in WB.
    // A load in the accepting IDLE cycle lands at that edge, so EXEC already
    // reads the new value.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = ld_addr;
        w_wdata = ld_data;
        case (r_state)
            IDLE: w_we = ld_en;
            WB: begin
                w_we    = r_ir.wen;
                w_waddr = r_ir.rd;
                w_wdata = r_res;
            end
            default: w_we = 1'b0;
        endcase
    end

    regfile4x4 u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_ra1      (r_ir.rs1),
        .o_rd1      (alu_a),
        .i_ra2      (r_ir.rs2),
        .o_rd2      (alu_b),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // alu-side controls come straight from IR so they are defined in every state.
    assign alu_cin   = r_ir.usec & r_flag_c;
    assign alu_aluop = r_ir.aluop;
    assign alu_l     = r_ir.l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ir       <= '0;
            r_res      <= '0;
            r_res_z    <= 1'b0;
            r_res_c    <= 1'b0;
            r_res_s    <= 1'b0;
            r_flag_z   <= 1'b0;
            r_flag_c   <= 1'b0;
            r_flag_s   <= 1'b0;
            r_in_ready <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ir       <= '{l: in_l, aluop: in_aluop, rd: in_rd,
                                        rs1: in_rs1, rs2: in_rs2,
                                        usec: in_usec, wen: in_wen};
                        r_state    <= EXEC;
                        r_in_ready <= 1'b0;
                    end
                end
                EXEC: begin
                    r_res   <= alu_r;
                    r_res_z <= alu_zero;
                    r_res_c <= alu_cout;
                    r_res_s <= alu_sign;
                    r_state <= WB;
                    r_done  <= 1'b1;
                end
                WB: begin
                    r_flag_z <= r_res_z;
                    r_flag_s <= r_res_s;
                    // Logic ops produce no meaningful carry; keep the old one.
                    if (r_ir.l == L_ARITH) begin
                        r_flag_c <= r_res_c;
                    end
                    r_state    <= IDLE;
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= IDLE;
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign done      = r_done;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_s    = r_flag_s;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: a reference alu stub closes the loop, a
// transaction-level model predicts registers/flags/handshake, a compare
// process checks every cycle, and directed steps pin literal results.
module tb_alu_issue_wb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_l = 1'b0;
    logic [1:0] in_aluop = 2'b00;
    logic [1:0] in_rd = 2'b00;
    logic [1:0] in_rs1 = 2'b00;
    logic [1:0] in_rs2 = 2'b00;
    logic       in_usec = 1'b0;
    logic       in_wen = 1'b0;
    logic       ld_en = 1'b0;
    logic [1:0] ld_addr = 2'b00;
    logic [3:0] ld_data = 4'h0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [1:0] alu_aluop;
    logic       alu_l;
    logic [3:0] alu_r;
    logic       alu_zero;
    logic       alu_cout;
    logic       alu_sign;
    logic       flag_z;
    logic       flag_c;
    logic       flag_s;
    logic       done;
    logic [1:0] dbg_addr = 2'b00;
    logic [3:0] dbg_data;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic checks_en = 1'b0;

    alu_issue_wb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_l      (in_l),
        .in_aluop  (in_aluop),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_usec   (in_usec),
        .in_wen    (in_wen),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_aluop (alu_aluop),
        .alu_l     (alu_l),
        .alu_r     (alu_r),
        .alu_zero  (alu_zero),
        .alu_cout  (alu_cout),
        .alu_sign  (alu_sign),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_s    (flag_s),
        .done      (done),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference alu: returns {R, zero, c_out, sign} ----------------
    function automatic logic [6:0] ref_alu(input logic l, input logic [1:0] op,
                                           input logic [3:0] a, input logic [3:0] b,
                                           input logic cin);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        s = 5'd0;
        r = 4'd0;
        c = 1'b0;
        if (!l) begin
            case (op)
                2'b00:   s = {1'b0, a} + {4'b0, cin};
                2'b01:   s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                2'b10:   s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
                default: s = {1'b0, a} + 5'h0F;
            endcase
            r = s[3:0];
            c = s[4];
        end else begin
            case (op)
                2'b00:   r = a & b;
                2'b01:   r = a | b;
                2'b10:   r = a ^ b;
                default: r = ~a;
            endcase
        end
        return {r, (r == 4'd0), c, r[3]};
    endfunction

    assign {alu_r, alu_zero, alu_cout, alu_sign} = ref_alu(alu_l, alu_aluop, alu_a, alu_b, alu_cin);

    // ---------------- transaction model ----------------
    // An accepted instruction is evaluated in full at accept time (after any
    // same-cycle load); its effects become visible after two more edges.
    logic [3:0] m_regs [4];
    logic       m_z, m_c, m_s;
    int         m_left;
    logic [3:0] m_a, m_b, m_r;
    logic       m_cin, m_l, m_wen, m_rz, m_rc, m_rs;
    logic [1:0] m_op, m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
            m_z = 1'b0; m_c = 1'b0; m_s = 1'b0;
            m_left = 0;
            m_a = 4'h0; m_b = 4'h0; m_cin = 1'b0; m_l = 1'b0; m_op = 2'b00;
        end else if (m_left == 0) begin
            if (ld_en) m_regs[ld_addr] = ld_data;
            if (in_valid) begin
                m_a   = m_regs[in_rs1];
                m_b   = m_regs[in_rs2];
                m_cin = in_usec & m_c;
                m_l   = in_l;
                m_op  = in_aluop;
                m_rd  = in_rd;
                m_wen = in_wen;
                {m_r, m_rz, m_rc, m_rs} = ref_alu(in_l, in_aluop, m_a, m_b, m_cin);
                m_left = 2;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_wen) m_regs[m_rd] = m_r;
                m_z = m_rz;
                m_s = m_rs;
                if (!m_l) m_c = m_rc;
            end
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always begin
        @(negedge clk);
        #1;
        if (checks_en && rst_n) begin
            check("in_ready", in_ready, (m_left == 0));
            check("done", done, (m_left == 1));
            check("flag_z", flag_z, m_z);
            check("flag_c", flag_c, m_c);
            check("flag_s", flag_s, m_s);
            check("dbg_data", dbg_data, m_regs[dbg_addr]);
            if (m_left == 2) begin
                check("alu_a", alu_a, m_a);
                check("alu_b", alu_b, m_b);
                check("alu_cin", alu_cin, m_cin);
                check("alu_aluop", alu_aluop, m_op);
                check("alu_l", alu_l, m_l);
            end
        end
    end

    // debug address sweeps continuously so every register is compared
    initial begin
        forever begin
            @(posedge clk);
            #1 dbg_addr = dbg_addr + 2'd1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [1:0] a, input logic [3:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic set_instr(input logic l, input logic [1:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2,
                             input logic usec, input logic wen);
        in_l = l; in_aluop = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_usec = usec; in_wen = wen;
    endtask

    // ld_mode: 0 none, 1 load in the accept cycle, 2 load held through EXEC/WB
    task automatic issue(input logic l, input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic usec, input logic wen, input int ld_mode,
                         input logic [1:0] la, input logic [3:0] ldd);
        int k;
        set_instr(l, op, rd, rs1, rs2, usec, wen);
        in_valid = 1'b1;
        if (ld_mode == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
        @(negedge clk);
        in_valid = 1'b0;
        ld_en = 1'b0;
        if (ld_mode == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
        k = 0;
        while (!done && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
        check("done_latency", k, 1);
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic read_reg(input string name, input logic [1:0] a, input logic [3:0] exp);
        int k;
        k = 0;
        while (dbg_addr != a && k < 8) begin
            @(negedge clk);
            k++;
        end
        check(name, dbg_data, exp);
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc, dn;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks_en = 1'b1;
        @(negedge clk);

        // reset state
        read_reg("rst_r0", 2'd0, 4'h0);
        read_reg("rst_r1", 2'd1, 4'h0);
        read_reg("rst_r2", 2'd2, 4'h0);
        read_reg("rst_r3", 2'd3, 4'h0);
        check("rst_flags", {flag_z, flag_c, flag_s}, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);

        // basic ADD: 5 + 3 = 8
        do_load(2'd1, 4'h5);
        do_load(2'd2, 4'h3);
        issue(1'b0, 2'b10, 2'd3, 2'd1, 2'd2, 1'b0, 1'b1, 0, 2'd0, 4'h0);
        read_reg("add_r3", 2'd3, 4'h8);
        check("add_zcs", {flag_z, flag_c, flag_s}, 3'b001);

        // carry out: F + 1 = 0 carry 1
        do_load(2'd1, 4'hF);
        do_load(2'd2, 4'h1);
        issue(1'b0, 2'b10, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 0, 2'd0, 4'h0);
        read_reg("carry_r0", 2'd0, 4'h0);
        check("carry_zcs", {flag_z, flag_c, flag_s}, 3'b110);

        // carry in: 2 + 2 + 1 = 5
        do_load(2'd1, 4'h2);
        do_load(2'd2, 4'h2);
        issue(1'b0, 2'b10, 2'd3, 2'd1, 2'd2, 1'b1, 1'b1, 0, 2'd0, 4'h0);
        read_reg("cin_r3", 2'd3, 4'h5);
        check("cin_c", flag_c, 0);

        // set C again, then AND C & A = 8 with flags-only write
        do_load(2'd1, 4'hF);
        do_load(2'd2, 4'h1);
        issue(1'b0, 2'b10, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 0, 2'd0, 4'h0);
        check("setc_c", flag_c, 1);
        do_load(2'd1, 4'hC);
        do_load(2'd2, 4'hA);
        issue(1'b1, 2'b00, 2'd1, 2'd1, 2'd2, 1'b0, 1'b0, 0, 2'd0, 4'h0);
        read_reg("and_r1_kept", 2'd1, 4'hC);
        check("and_zcs", {flag_z, flag_c, flag_s}, 3'b011);

        // XOR A ^ A = 0 into r3, carry untouched
        issue(1'b1, 2'b10, 2'd3, 2'd2, 2'd2, 1'b0, 1'b1, 0, 2'd0, 4'h0);
        read_reg("xor_r3", 2'd3, 4'h0);
        check("xor_zcs", {flag_z, flag_c, flag_s}, 3'b110);

        // load during EXEC/WB ignored; C + A = 0x16
        issue(1'b0, 2'b10, 2'd3, 2'd1, 2'd2, 1'b0, 1'b1, 2, 2'd0, 4'hF);
        read_reg("busyld_r0", 2'd0, 4'h0);
        read_reg("busyld_r3", 2'd3, 4'h6);

        // load together with accept: r3=9, then 9 + 9 = 0x12
        issue(1'b0, 2'b10, 2'd0, 2'd3, 2'd3, 1'b0, 1'b1, 1, 2'd3, 4'h9);
        read_reg("coll_r3", 2'd3, 4'h9);
        read_reg("coll_r0", 2'd0, 4'h2);
        check("coll_zcs", {flag_z, flag_c, flag_s}, 3'b010);

        // backpressure: valid held 9 cycles -> three accepted increments
        do_load(2'd1, 4'h0);
        do_load(2'd2, 4'h1);
        set_instr(1'b0, 2'b10, 2'd1, 2'd1, 2'd2, 1'b0, 1'b1);
        in_valid = 1'b1;
        acc = 0;
        dn = 0;
        for (int i = 0; i < 9; i++) begin
            if (in_ready) acc++;
            @(negedge clk);
            if (done) dn++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepts", acc, 3);
        check("bp_dones", dn, 3);
        read_reg("bp_r1", 2'd1, 4'h3);

        // reset during EXEC of 5 + 2 -> r2
        do_load(2'd1, 4'h5);
        do_load(2'd0, 4'h2);
        set_instr(1'b0, 2'b10, 2'd2, 2'd1, 2'd0, 1'b0, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort_in_exec", dbg_state, 1);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        read_reg("abort_r2", 2'd2, 4'h0);
        read_reg("abort_r1", 2'd1, 4'h0);
        check("abort_flags", {flag_z, flag_c, flag_s}, 0);
        check("abort_state", dbg_state, 0);
        check("abort_done", done, 0);
        check("abort_ready", in_ready, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
